// File: rtl/display_decoder.sv
// display_decoder
//   Time-multiplexed 4-digit 7-segment driver (mm:ss) for the front panel.
//   A shadow register captures bcd_in on load. The shadow is copied to the
//   displayed value only at frame boundaries, so a frame is never torn.
//   Digits are scanned one per SCAN_DIV clocks. Leading-zero blanking, a
//   colon point on digit 2, and a frame-counted blink are provided.
// Ports
//   clk, rst       clock, async active-high reset
//   load, bcd_in   capture {d3,d2,d1,d0} BCD into the shadow register
//   blank_lz       blank leading zero digits d3..d1
//   colon_en       light dp while digit 2 is selected
//   blink_en       blank everything during odd blink phases
//   seg, dp, an    registered segments {g..a}, point, one-hot digit select

module seg7_dec (
  input  logic [3:0] d,
  output logic [6:0] seg
);
  always_comb begin
    seg = 7'b1000000;  // dash for non-BCD codes
    case (d)
      4'd0: seg = 7'b0111111;
      4'd1: seg = 7'b0000110;
      4'd2: seg = 7'b1011011;
      4'd3: seg = 7'b1001111;
      4'd4: seg = 7'b1100110;
      4'd5: seg = 7'b1101101;
      4'd6: seg = 7'b1111101;
      4'd7: seg = 7'b0000111;
      4'd8: seg = 7'b1111111;
      4'd9: seg = 7'b1101111;
      default: seg = 7'b1000000;
    endcase
  end
endmodule

module display_decoder #(
  parameter int SCAN_DIV     = 100,
  parameter int BLINK_FRAMES = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic [15:0] bcd_in,
  input  logic        blank_lz,
  input  logic        colon_en,
  input  logic        blink_en,
  output logic [6:0]  seg,
  output logic        dp,
  output logic [3:0]  an
);
  localparam int CW = $clog2(SCAN_DIV);
  localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  logic [CW-1:0]      cnt;
  logic [1:0]         idx;
  logic [FW-1:0]      fcnt;
  logic               phase;
  logic [15:0]        shadow;
  logic [3:0][3:0]    disp;
  logic [3:0][6:0]    seg_dig;
  logic [3:0]         lz;
  logic               tick, frame;

  assign tick  = (cnt == CW'(SCAN_DIV - 1));
  assign frame = tick && (idx == 2'd3);

  // Scan prescaler, digit index, frame/blink counters, shadow/display regs.
  // A load on a boundary edge is seen by shadow only; disp takes the old
  // shadow and the new value shows one frame later.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt    <= '0;
      idx    <= '0;
      fcnt   <= '0;
      phase  <= 1'b0;
      shadow <= '0;
      disp   <= '0;
    end else begin
      cnt <= tick ? '0 : cnt + 1'b1;
      if (tick) idx <= idx + 2'd1;
      if (frame) begin
        disp <= shadow;
        if (fcnt == FW'(BLINK_FRAMES - 1)) begin
          fcnt  <= '0;
          phase <= ~phase;
        end else begin
          fcnt <= fcnt + 1'b1;
        end
      end
      if (load) shadow <= bcd_in;
    end
  end

  // One decoder per digit; the scan mux picks the selected one.
  for (genvar g = 0; g < 4; g++) begin : g_dec
    seg7_dec u_dec (.d(disp[g]), .seg(seg_dig[g]));
  end

  // A digit is a leading zero if it and every higher digit are zero.
  always_comb begin
    lz    = '0;
    lz[3] = blank_lz && (disp[3] == 4'd0);
    lz[2] = lz[3] && (disp[2] == 4'd0);
    lz[1] = lz[2] && (disp[1] == 4'd0);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      seg <= '0;
      dp  <= 1'b0;
      an  <= '0;
    end else if (blink_en && phase) begin
      seg <= '0;
      dp  <= 1'b0;
      an  <= '0;
    end else begin
      an  <= 4'b0001 << idx;
      seg <= lz[idx] ? 7'd0 : seg_dig[idx];
      dp  <= colon_en && (idx == 2'd2) && !lz[idx];
    end
  end
endmodule
